// File: rtl/fetch_stage.sv
// Instruction fetch stage: a word-indexed PC register, a three-state fetch FSM
// (START/RUN/HALT) and the IF/ID pipeline register feeding decode.
module fetch_stage #(
    parameter int unsigned IMEM_DEPTH = 400,
    parameter logic [31:0] RESET_PC   = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic        halted
);

    localparam logic [1:0] ST_START = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic [31:0] DEPTH = 32'(IMEM_DEPTH);

    logic [1:0]  state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] ifpc_reg, ifpc_next;
    logic        valid_reg, valid_next;
    logic [31:0] pc_plus1;

    assign pc_plus1 = pc_reg + 32'd1;

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = instr_reg;
        ifpc_next  = ifpc_reg;
        valid_next = valid_reg;
        case (state_reg)
            ST_START: begin
                // Stall and redirect are both ignored for this single cycle.
                pc_next    = RESET_PC;
                instr_next = 32'd0;
                ifpc_next  = 32'd0;
                valid_next = 1'b0;
                state_next = ST_RUN;
            end
            ST_RUN, ST_HALT: begin
                if (branch_taken) begin
                    instr_next = 32'd0;
                    ifpc_next  = 32'd0;
                    valid_next = 1'b0;
                    if (branch_target < DEPTH) begin
                        pc_next    = branch_target;
                        state_next = ST_RUN;
                    end else begin
                        state_next = ST_HALT;
                    end
                end else if (state_reg == ST_HALT) begin
                    instr_next = 32'd0;
                    ifpc_next  = 32'd0;
                    valid_next = 1'b0;
                end else if (!stall) begin
                    // The last word is still delivered; pc parks on it.
                    instr_next = instruction;
                    ifpc_next  = pc_reg;
                    valid_next = 1'b1;
                    if (pc_plus1 >= DEPTH) begin
                        state_next = ST_HALT;
                    end else begin
                        pc_next = pc_plus1;
                    end
                end
            end
            default: begin
                state_next = ST_START;
                pc_next    = RESET_PC;
                instr_next = 32'd0;
                ifpc_next  = 32'd0;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_START;
            pc_reg    <= RESET_PC;
            instr_reg <= 32'd0;
            ifpc_reg  <= 32'd0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            ifpc_reg  <= ifpc_next;
            valid_reg <= valid_next;
        end
    end

    assign pc          = pc_reg;
    assign if_id_instr = instr_reg;
    assign if_id_pc    = ifpc_reg;
    assign if_id_valid = valid_reg;
    assign halted      = (state_reg == ST_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory word k holds k+0x100, so every
// captured instruction is predictable from its word index.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic        halted;

    int passed = 0;
    int total  = 0;

    fetch_stage #(.IMEM_DEPTH(400), .RESET_PC(32'd0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .instruction  (instruction),
        .pc           (pc),
        .if_id_instr  (if_id_instr),
        .if_id_pc     (if_id_pc),
        .if_id_valid  (if_id_valid),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign instruction = pc + 32'h100;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Expected full observable state after a step.
    task automatic expect_all(input string tag, input logic [31:0] e_pc,
                              input logic [31:0] e_instr, input logic [31:0] e_ifpc,
                              input logic e_valid, input logic e_halted);
        check({tag, ".pc"},     pc,          e_pc);
        check({tag, ".instr"},  if_id_instr, e_instr);
        check({tag, ".ifpc"},   if_id_pc,    e_ifpc);
        check({tag, ".valid"},  {31'd0, if_id_valid}, {31'd0, e_valid});
        check({tag, ".halted"}, {31'd0, halted},      {31'd0, e_halted});
        $display("step %-10s pc=%0d if_id=(%h,%0d,%b) halted=%b",
                 tag, pc, if_id_instr, if_id_pc, if_id_valid, halted);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
        repeat (2) @(negedge clk);
        expect_all("reset", 0, 0, 0, 1'b0, 1'b0);

        // Start-up and sequential fetch.
        rst_n = 1'b1;
        tick(); expect_all("start", 0, 0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick(); expect_all("seq", k + 1, k + 32'h100, k, 1'b1, 1'b0);
        end

        // Stall at pc=5 holds everything.
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(); expect_all("stall", 5, 32'h104, 4, 1'b1, 1'b0);
        end
        stall = 1'b0;
        tick(); expect_all("release", 6, 32'h105, 5, 1'b1, 1'b0);

        // Redirect wins over stall.
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'd20;
        tick(); expect_all("br20", 20, 0, 0, 1'b0, 1'b0);
        stall = 1'b0; branch_taken = 1'b0;
        tick(); expect_all("br20+1", 21, 32'h114, 20, 1'b1, 1'b0);

        // Run off the end of memory.
        branch_taken = 1'b1; branch_target = 32'd395;
        tick(); expect_all("br395", 395, 0, 0, 1'b0, 1'b0);
        branch_taken = 1'b0;
        for (int k = 395; k < 399; k++) begin
            tick(); expect_all("tail", k + 1, k + 32'h100, k, 1'b1, 1'b0);
        end
        tick(); expect_all("last", 399, 32'h28F, 399, 1'b1, 1'b1);
        tick(); expect_all("halt1", 399, 0, 0, 1'b0, 1'b1);
        tick(); expect_all("halt2", 399, 0, 0, 1'b0, 1'b1);

        // Redirect out of HALT.
        branch_taken = 1'b1; branch_target = 32'd7;
        tick(); expect_all("br7", 7, 0, 0, 1'b0, 1'b0);
        branch_taken = 1'b0;
        tick(); expect_all("br7+1", 8, 32'h107, 7, 1'b1, 1'b0);

        // Out-of-range target halts with pc held.
        branch_taken = 1'b1; branch_target = 32'd400;
        tick(); expect_all("br400", 8, 0, 0, 1'b0, 1'b1);
        branch_taken = 1'b0;
        tick(); expect_all("br400+1", 8, 0, 0, 1'b0, 1'b1);

        // Asynchronous reset while stalled at pc=9.
        branch_taken = 1'b1; branch_target = 32'd8;
        tick(); expect_all("br8", 8, 0, 0, 1'b0, 1'b0);
        branch_taken = 1'b0;
        tick(); expect_all("br8+1", 9, 32'h108, 8, 1'b1, 1'b0);
        stall = 1'b1;
        tick(); expect_all("stall9", 9, 32'h108, 8, 1'b1, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0; branch_taken = 1'b1; branch_target = 32'd30;
        #1;
        expect_all("arst", 0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1; branch_taken = 1'b0;
        tick(); expect_all("restart", 0, 0, 0, 1'b0, 1'b0);
        stall = 1'b0;
        tick(); expect_all("restart+1", 1, 32'h100, 0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
